kamus_lsu_ctrl: RTL
===================

Name: kamus_lsu_ctrl

Overview:
Parametrised load/store unit for the kamus core, sitting between EX/MEM and the data-memory port. Accepts one load/store request at a time over a valid/ready handshake. Computes byte enables, aligns write data and drives a req/gnt/rvalid data bus. Splits misaligned accesses into two bus beats, and sign- or zero-extends load data before a one-cycle response pulse.

Parameters:
DATA_W, 32, bus and register data width; legal values 32 or 64.
ADDR_W, 32, byte-address width.
SPLIT_MISALIGNED, 1, 1 = split a line-crossing access into two beats; 0 = return an error with no bus access.
BE_W, DATA_W/8, derived; byte enables per beat.
OFF_W, log2(BE_W), derived; byte offset within a beat.

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  unit can accept a request
req_we_i  in  1  1 = store, 0 = load
req_width_i  in  mem_width_t  B/H/W, plus D when DATA_W=64
req_unsigned_i  in  1  zero-extend load (LBU/LHU/LWU)
req_addr_i  in  ADDR_W  byte address
req_wdata_i  in  DATA_W  store data, LSB-justified
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  DATA_W  extended load data; 0 for stores
rsp_err_o  out  1  misaligned with SPLIT_MISALIGNED=0, or illegal width
dmem_req_o  out  1  bus request
dmem_gnt_i  in  1  bus grant
dmem_we_o  out  1  bus write
dmem_be_o  out  BE_W  byte enables
dmem_addr_o  out  ADDR_W  beat-aligned address (low OFF_W bits = 0)
dmem_wdata_o  out  DATA_W  lane-aligned write data
dmem_rvalid_i  in  1  beat complete; asserted for both loads and stores
dmem_rdata_i  in  DATA_W  read data

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): state IDLE. Outputs: req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0.
- Reset mid-transaction abandons the transaction. No response is produced. The bus owner must tolerate a dropped outstanding beat.
- Request is accepted on req_valid_i && req_ready_o. req_ready_o=1 only in IDLE. All request fields are registered on acceptance.
- Offset and masks:
  - off = addr[OFF_W-1:0].
  - mask2 (2*BE_W bits) = width mask (B=1, H=3, W=F, D=FF) << off.
  - wide write data (2*DATA_W) = wdata << (8*off).
  - Beat0 uses the low halves; beat1 uses the high halves at address base+BE_W.
  - The access is split iff the upper half of mask2 is nonzero.
- States:
  - IDLE.
  - REQ0: dmem_req_o=1 and beat-0 bus signals held stable until dmem_gnt_i.
  - WAIT0: wait for dmem_rvalid_i; capture rdata into the low half.
  - REQ1 / WAIT1: same as REQ0 / WAIT0 for beat 1, capturing into the high half.
  - RESP: rsp_valid_o=1 for exactly one cycle, then IDLE.
- Transitions:
  - IDLE→REQ0 on accept.
  - IDLE→RESP with err=1 on accept if split is needed and SPLIT_MISALIGNED=0, or the width is illegal.
  - REQ0→WAIT0 on gnt.
  - WAIT0→REQ1 on rvalid if split, else WAIT0→RESP.
  - REQ1→WAIT1 on gnt; WAIT1→RESP on rvalid.
- rvalid arriving in the same cycle as gnt is not permitted. The earliest rvalid is one cycle after gnt.
- Load result:
  - Shift the 2*DATA_W capture right by 8*off and take the width bytes.
  - Sign-extend from the top data bit unless req_unsigned_i=1.
  - For a store, rsp_rdata_o=0.
- Minimum latency (gnt immediate, rvalid one cycle later): accept at cycle 0, rsp_valid_o at cycle 3 (aligned) or cycle 5 (split).
- Between transactions, dmem_req_o=0 and dmem_be_o=0.

Decomposition:
- kamus_pkg holds:
  - mem_width_t (B, H, W, D).
  - lsu_state_t.
  - Width-to-mask function: returns all-zero for an illegal width; never x.
- One sub-module, kamus_lsu_align (combinational). Inputs: width, off, unsigned flag, wdata, capture. Outputs: mask2, wide wdata, extended rdata.
- The controller FSM stays in kamus_lsu_ctrl.

Test Plan:
- DATA_W=32. LW at addr 0x100, gnt immediate, rdata=0xDEADBEEF → dmem_be_o=1111, dmem_addr_o=0x100; rsp_rdata_o=0xDEADBEEF with rsp_valid_o at cycle 3.
- LB at 0x103, rdata=0x80FFFFFF → be=1000; rsp_rdata_o=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x102, wdata=0x1234ABCD → one beat: be=1100, dmem_wdata_o=0xABCD0000, dmem_we_o=1; rsp_rdata_o=0.
- LW at 0x0FE, SPLIT_MISALIGNED=1:
  - Beat0: addr=0x0FC, be=1100, rdata=0xAAAA5555.
  - Beat1: addr=0x100, be=0011, rdata=0x7777BBBB.
  - Response: rsp_rdata_o=0xBBBBAAAA at cycle 5.
- Same LW at 0x0FE with SPLIT_MISALIGNED=0 → no dmem_req_o; rsp_err_o=1 at cycle 1.
- dmem_gnt_i held low for 4 cycles, then rst_ni=0 during WAIT0 → REQ0 signals stable while waiting; after reset, all outputs at reset values, no rsp_valid_o, req_ready_o=1.

Source files
------------

// File: rtl/kamus_pkg.sv
// kamus_pkg: shared types and helpers for the kamus load/store unit
package kamus_pkg;
  typedef enum logic [1:0] {MW_B, MW_H, MW_W, MW_D} mem_width_t;
  typedef enum logic [2:0] {S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP} lsu_state_t;
  // An illegal width yields an all-zero mask, which the controller treats as an error.
  function automatic logic [7:0] width_mask(mem_width_t w, int unsigned be_w);
    logic [7:0] m;
    case (w)
      MW_B: m = 8'h01;
      MW_H: m = 8'h03;
      MW_W: m = 8'h0f;
      MW_D: m = (be_w == 8) ? 8'hff : 8'h00;
      default: m = 8'h00;
    endcase
    return m;
  endfunction
endpackage

// File: rtl/kamus_lsu_align.sv
// kamus_lsu_align: byte-enable, write-lane and load-extension datapath
module kamus_lsu_align
  import kamus_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int BE_W = DATA_W / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  input  mem_width_t          width,
  input  logic [OFF_W-1:0]    off,
  input  logic                is_unsigned,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [2*DATA_W-1:0] capture,
  output logic [2*BE_W-1:0]   mask2,
  output logic [2*DATA_W-1:0] wdata2,
  output logic [DATA_W-1:0]   rdata
);
  logic [BE_W-1:0] wmask;
  logic [2*DATA_W-1:0] shifted;
  logic [7:0] nbits;
  logic sign;
  assign wmask = BE_W'(width_mask(width, BE_W));
  assign mask2 = {{BE_W{1'b0}}, wmask} << off;
  assign wdata2 = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
  assign shifted = capture >> {off, 3'b000};
  assign nbits = 8'd8 << width;
  always_comb begin
    case (width)
      MW_B: sign = shifted[7];
      MW_H: sign = shifted[15];
      MW_W: sign = shifted[31];
      default: sign = shifted[DATA_W-1];
    endcase
    for (int i = 0; i < DATA_W; i++)
      rdata[i] = (i < int'(nbits)) ? shifted[i] : (!is_unsigned && sign);
  end
endmodule

// File: rtl/kamus_lsu_ctrl.sv
// kamus_lsu_ctrl: single-outstanding load/store unit driving a req/gnt/rvalid data bus
module kamus_lsu_ctrl
  import kamus_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1,
  localparam int BE_W = DATA_W / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  mem_width_t        req_width_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic              dmem_we_o,
  output logic [BE_W-1:0]   dmem_be_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i
);
  lsu_state_t state, state_n;
  logic r_we, r_uns, r_err;
  mem_width_t r_width, a_width;
  logic [OFF_W-1:0] r_off, a_off;
  logic [ADDR_W-1:0] r_base;
  logic [2*BE_W-1:0] r_mask2, mask2;
  logic [2*DATA_W-1:0] r_wdata2, r_cap, wdata2;
  logic [DATA_W-1:0] ext;
  logic idle, accept, split, r_split, bad, beat1;
  assign idle = state == S_IDLE;
  // While idle the aligner sees the incoming request; afterwards, the registered one.
  assign a_width = idle ? req_width_i : r_width;
  assign a_off = idle ? req_addr_i[OFF_W-1:0] : r_off;
  assign accept = req_valid_i && req_ready_o;
  assign split = |mask2[2*BE_W-1:BE_W];
  assign r_split = |r_mask2[2*BE_W-1:BE_W];
  assign bad = mask2 == '0 || (split && !SPLIT_MISALIGNED);
  kamus_lsu_align #(.DATA_W(DATA_W)) u_align (
    .width(a_width),
    .off(a_off),
    .is_unsigned(r_uns),
    .wdata(req_wdata_i),
    .capture(r_cap),
    .mask2(mask2),
    .wdata2(wdata2),
    .rdata(ext)
  );
  always_ff @(posedge clk_i)
    if (!rst_ni) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = accept ? (bad ? S_RESP : S_REQ0) : S_IDLE;
      S_REQ0: state_n = dmem_gnt_i ? S_WAIT0 : S_REQ0;
      S_WAIT0: state_n = dmem_rvalid_i ? (r_split ? S_REQ1 : S_RESP) : S_WAIT0;
      S_REQ1: state_n = dmem_gnt_i ? S_WAIT1 : S_REQ1;
      S_WAIT1: state_n = dmem_rvalid_i ? S_RESP : S_WAIT1;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_we <= 1'b0;
      r_uns <= 1'b0;
      r_err <= 1'b0;
      r_width <= MW_B;
      r_off <= '0;
      r_base <= '0;
      r_mask2 <= '0;
      r_wdata2 <= '0;
      r_cap <= '0;
    end else begin
      if (accept) begin
        r_we <= req_we_i;
        r_uns <= req_unsigned_i;
        r_err <= bad;
        r_width <= req_width_i;
        r_off <= req_addr_i[OFF_W-1:0];
        r_base <= {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        r_mask2 <= mask2;
        r_wdata2 <= wdata2;
        r_cap <= '0;
      end
      if (state == S_WAIT0 && dmem_rvalid_i) r_cap[DATA_W-1:0] <= dmem_rdata_i;
      if (state == S_WAIT1 && dmem_rvalid_i) r_cap[2*DATA_W-1:DATA_W] <= dmem_rdata_i;
    end
  end
  assign beat1 = state == S_REQ1;
  assign req_ready_o = idle;
  assign dmem_req_o = state == S_REQ0 || beat1;
  assign dmem_we_o = dmem_req_o && r_we;
  assign dmem_be_o = state == S_REQ0 ? r_mask2[BE_W-1:0] : beat1 ? r_mask2[2*BE_W-1:BE_W] : '0;
  assign dmem_addr_o = state == S_REQ0 ? r_base : beat1 ? r_base + ADDR_W'(BE_W) : '0;
  assign dmem_wdata_o = state == S_REQ0 ? r_wdata2[DATA_W-1:0] : beat1 ? r_wdata2[2*DATA_W-1:DATA_W] : '0;
  assign rsp_valid_o = state == S_RESP;
  assign rsp_err_o = rsp_valid_o && r_err;
  assign rsp_rdata_o = (rsp_valid_o && !r_we && !r_err) ? ext : '0;
endmodule
